// File: rtl/datapath_sequencer.sv
// Control sequencer for a small register-file datapath: accepts one instruction in IDLE,
// then walks LOADT/EXEC/DONE emitting write, tmp-load and mux selects for that instruction.
module datapath_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [1:0] rd,
  output logic [1:0] sr,
  output logic [1:0] Rn,
  output logic       w,
  output logic [1:0] aluop,
  output logic       lt,
  output logic [2:0] tsel,
  output logic [2:0] bsel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] dbg_state
);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOADT = 2'b01,
    EXEC  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] ra_q;
  logic [1:0] rb_q;
  logic [1:0] rd_q;
  logic       bad_q;
  logic       illegal;
  logic       is_alu;

  function automatic logic [2:0] onehot(input logic [1:0] r);
    case (r)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // SHL and MOVI never read the B bus, so rb=00 is only illegal for XOR/AND/MOV.
  always_comb begin
    illegal = (op > OP_MOV) ||
              (((op == OP_XOR) || (op == OP_AND) || (op == OP_MOV)) && (rb == 2'd0));
    is_alu  = (op == OP_XOR) || (op == OP_AND) || (op == OP_SHL);
  end

  // start is a request qualified by IDLE only: it is accepted on a rising edge where
  // state is IDLE and start=1; while busy (including the DONE cycle) it is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 3'd0;
      ra_q  <= 2'd0;
      rb_q  <= 2'd0;
      rd_q  <= 2'd0;
      bad_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            ra_q  <= ra;
            rb_q  <= rb;
            rd_q  <= rd;
            bad_q <= illegal;
            if (illegal)     state <= DONE;
            else if (is_alu) state <= LOADT;
            else             state <= EXEC;
          end
        end
        LOADT:   state <= EXEC;
        EXEC:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sr    = 2'b00;
    Rn    = 2'b00;
    w     = 1'b0;
    aluop = 2'b00;
    lt    = 1'b0;
    tsel  = 3'b000;
    bsel  = 3'b000;
    done  = 1'b0;
    err   = 1'b0;
    case (state)
      LOADT: begin
        lt = 1'b1;
        if (ra_q == 2'd0) begin
          tsel = 3'b010;
        end else begin
          tsel = 3'b100;
          bsel = onehot(ra_q);
        end
      end
      EXEC: begin
        w  = 1'b1;
        Rn = rd_q;
        sr = (op_q == OP_MOVI) ? 2'b00 : 2'b01;
        case (op_q)
          OP_XOR:  aluop = 2'b00;
          OP_AND:  aluop = 2'b01;
          OP_SHL:  aluop = 2'b10;
          OP_MOV:  aluop = 2'b11;
          default: aluop = 2'b00;
        endcase
        bsel = ((op_q == OP_SHL) || (op_q == OP_MOVI)) ? 3'b001 : onehot(rb_q);
      end
      DONE: begin
        done = 1'b1;
        err  = bad_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
